// File: rtl/pipe_latch_skid.sv
// Pipeline latch with optional two-entry skid buffer and flush-to-bubble.
// Define PIPE_LATCH_SKID_EN for the registered-ready skid variant.
module pipe_latch_skid #(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic push;
    logic pop;

    assign push = in_valid & in_ready & en & ~flush;
    assign pop  = out_valid & out_ready & en & ~flush;

`ifdef PIPE_LATCH_SKID_EN

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              in_ready_q;
    logic              in_ready_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: if (push) state_d = S_ONE;
                S_ONE: begin
                    if (push && !pop)      state_d = S_TWO;
                    else if (pop && !push) state_d = S_EMPTY;
                end
                S_TWO:   if (pop) state_d = S_ONE;
                default: state_d = S_EMPTY;
            endcase
        end
        // ready is a flop: it looks at the next state, never at out_ready
        in_ready_d = (state_d != S_TWO);
    end

    always_comb begin
        out_valid = (state_q != S_EMPTY);
        in_ready  = in_ready_q;
        count     = state_q;
        out_data  = main_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_q <= BUBBLE_VAL;
            skid_q <= BUBBLE_VAL;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // main is restored to the bubble whenever it empties
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = BUBBLE_VAL;
            skid_d = BUBBLE_VAL;
        end else begin
            unique case (state_q)
                S_EMPTY: if (push) main_d = in_data;
                S_ONE: begin
                    if (push && pop) main_d = in_data;
                    else if (push)   skid_d = in_data;
                    else if (pop)    main_d = BUBBLE_VAL;
                end
                S_TWO: begin
                    if (pop) begin
                        main_d = skid_q;
                        skid_d = BUBBLE_VAL;
                    end
                end
                default: begin
                    main_d = BUBBLE_VAL;
                    skid_d = BUBBLE_VAL;
                end
            endcase
        end
    end

`else

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            main_q  <= BUBBLE_VAL;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
            main_d  = BUBBLE_VAL;
        end else if (push) begin
            valid_d = 1'b1;
            main_d  = in_data;
        end else if (pop) begin
            valid_d = 1'b0;
            main_d  = BUBBLE_VAL;
        end
    end

    always_comb begin
        out_valid = valid_q;
        in_ready  = ~valid_q | out_ready;
        count     = {1'b0, valid_q};
        out_data  = main_q;
    end

`endif

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Scoreboard bench for pipe_latch_skid: queue model, directed and random traffic.
module tb_pipe_latch_skid;

    localparam int unsigned DW  = 32;
    localparam logic [DW-1:0] BUB = 32'h0000_0013;
`ifdef PIPE_LATCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          CLK;
    logic          nRST;
    logic          en;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    pipe_latch_skid #(
        .DATA_W    (DW),
        .BUBBLE_VAL(BUB)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .en       (en),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Observable state expected from the queue contents alone
    task automatic chk_state();
        logic [DW-1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : BUB;
        chk("count", DW'(count), DW'(exp_q.size()));
        chk("out_valid", DW'(out_valid), DW'(exp_q.size() > 0));
        chk("out_data", out_data, head);
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] d,
                        input logic ordy, input logic e, input logic fl);
        logic exp_rdy;
        @(negedge CLK);
        chk_state();
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        en        = e;
        flush     = fl;
        #1;
        if (CAP == 2) exp_rdy = (exp_q.size() < 2);
        else          exp_rdy = (exp_q.size() == 0) || ordy;
        chk("in_ready", DW'(in_ready), DW'(exp_rdy));
        @(posedge CLK);
        if (fl)                        exp_q.delete();
        else if (iv && exp_rdy && e)   exp_q.push_back(d);
    endtask

    // Monitor: a transfer that will happen at the coming edge pops the scoreboard
    always @(negedge CLK) begin
        #2;
        if (nRST && out_valid && out_ready && en && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_underflow: got %h expected no output", out_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h at %0t", out_data, e, $time);
                end
            end
        end
    end

    task automatic async_reset();
        @(negedge CLK);
        #3 nRST = 1'b0;
        #1;
        chk("rst_count", DW'(count), '0);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data", out_data, BUB);
        chk("rst_in_ready", DW'(in_ready), 32'd1);
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        en        = 1'b1;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST      = 1'b0;
        en        = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("init_count", DW'(count), '0);
        chk("init_out_data", out_data, BUB);
        chk("init_in_ready", DW'(in_ready), 32'd1);
        @(negedge CLK);
        nRST = 1'b1;

        // single push, one-cycle latency
        step(1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // fill while downstream stalls, then drain
        step(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // streaming
        for (int i = 0; i < 100; i++) step(1'b1, DW'(i), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // flush beats a same-cycle push
        step(1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // enable low freezes a held entry
        step(1'b1, 32'h66, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h77 + DW'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // asynchronous reset while full, then reuse
        step(1'b1, 32'h88, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
        async_reset();
        step(1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                 ($urandom % 5) != 0, ($urandom % 30) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        chk_state();
        chk("drained", DW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_latch_skid.md
PIPE_LATCH_SKID -- requirements
Module: pipe_latch_skid

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, meaning the width of the stage payload in bits.
REQ-002 The block SHALL provide parameter BUBBLE_VAL, default 0, meaning the payload value presented when the stage is flushed or empty (a nop).
REQ-003 Port CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port nRST  input  1  is the asynchronous, active-low reset.
REQ-005 Port en  input  1  is the stage enable; 0 freezes all state.
REQ-006 Port flush  input  1  discards all held entries.
REQ-007 Port in_valid  input  1  means the upstream stage presents a payload.
REQ-008 Port in_data  input  DATA_W  is the upstream payload.
REQ-009 Port in_ready  output  1  means the block accepts a payload this cycle.
REQ-010 Port out_valid  output  1  means out_data holds a live payload.
REQ-011 Port out_data  output  DATA_W  is the downstream payload.
REQ-012 Port out_ready  input  1  means the downstream stage consumes out_data this cycle.
REQ-013 Port count  output  2  is the number of held entries (0..2).

Function
REQ-014 Push SHALL occur when in_valid & in_ready & en & !flush; pop SHALL occur when out_valid & out_ready & en & !flush.
REQ-015 Storage SHALL be a main register (drives out_data) plus one skid register; the states are EMPTY (count 0), ONE (count 1) and TWO (count 2).
REQ-016 In EMPTY, a push SHALL load main and go to ONE.
REQ-017 In ONE, a push without pop SHALL load skid and go to TWO.
REQ-018 In ONE, a simultaneous push and pop SHALL load main with in_data and stay in ONE.
REQ-019 In ONE, a pop alone SHALL go to EMPTY.
REQ-020 In TWO, a pop SHALL move skid into main and go to ONE; no push is possible in TWO.
REQ-021 in_ready SHALL be registered: 1 in EMPTY and ONE, 0 in TWO, with no combinational path from out_ready.
REQ-022 Latency SHALL be 1 cycle: data pushed at edge N is on out_data after edge N when main was free.
REQ-023 Order SHALL be strictly FIFO; no payload may be dropped or duplicated except on flush.
REQ-024 When out_valid=0, out_data SHALL equal BUBBLE_VAL.
REQ-025 flush SHALL take priority over push, pop and en: at the next edge the block goes to EMPTY, count=0, out_valid=0 and out_data=BUBBLE_VAL, and any same-cycle input is discarded.
REQ-026 When en=0 and flush=0, state, count and outputs SHALL hold; in_ready still reflects the held state, but no transfer occurs.
REQ-027 count SHALL always equal the number of live entries and SHALL never exceed 2.

Reset
REQ-028 Asserting nRST low SHALL immediately force EMPTY, count=0, out_valid=0, out_data=BUBBLE_VAL, in_ready=1 and skid=BUBBLE_VAL, independent of CLK.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; the first push after deassertion is accepted at the first rising edge with nRST=1.

Configuration
REQ-030 Macro PIPE_LATCH_SKID_EN defined SHALL build the two-entry skid behaviour of REQ-015..REQ-021.
REQ-031 Without PIPE_LATCH_SKID_EN, the skid register SHALL be absent and these changes SHALL apply:
- in_ready = !out_valid | out_ready, combinational;
- count is 0 or 1 only;
- all other rules (priority, bubble, reset) are unchanged.

Verification
REQ-032 Reset, then push 0xA5A5_0001 with out_ready=1 -> after 1 edge, out_valid=1, out_data=0xA5A5_0001, count=1.
REQ-033 out_ready=0, push 0x11 then 0x22 (macro on) -> count=2, in_ready=0; then out_ready=1 -> out_data 0x11 then 0x22 on consecutive cycles, then out_valid=0 and out_data=BUBBLE_VAL.
REQ-034 Streaming 0..99 with in_valid=out_ready=1 each cycle -> 100 outputs in order, throughput 1 per cycle, count stays 1.
REQ-035 In TWO, assert flush together with in_valid=1, in_data=0x33 -> next edge: count=0, out_valid=0, out_data=BUBBLE_VAL, and 0x33 is never output.
REQ-036 Hold en=0 for 5 cycles with in_valid=1, out_ready=1 in ONE -> out_data and count unchanged and no pop; en=1 resumes correctly.
REQ-037 Drop nRST asynchronously between edges while in TWO -> outputs reach reset values before the next edge; rerun REQ-032 and REQ-033 with the macro undefined to check the single-register mode.
